uart_tx_arbiter: RTL and testbench

//  Shares the UART transmit path (wr_uart/w_data/tx_full of the UART top) among NREQ

---
 rtl/uart_tx_arbiter.sv | 133 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-locked round-robin arbiter that shares one UART TX
// FIFO write port among NREQ byte-stream requesters, with a stall watchdog
// that reclaims the grant from an owner that goes silent mid-packet.
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int DBIT    = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [NREQ-1:0]      i_req_valid,
  input  logic [NREQ*DBIT-1:0] i_req_data,
  input  logic [NREQ-1:0]      i_req_last,
  output logic [NREQ-1:0]      o_req_ready,
  input  logic                 i_tx_full,
  output logic                 o_wr_uart,
  output logic [DBIT-1:0]      o_w_data,
  output logic [NREQ-1:0]      o_grant,
  output logic                 o_busy,
  output logic                 o_timeout_err
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t          r_state;
  logic [NREQ-1:0] r_grant;
  logic [PW-1:0]   r_idx;
  logic [PW-1:0]   r_ptr;
  logic [WW-1:0]   r_wd;
  logic            r_tmo;

  logic            w_sel_valid;
  logic            w_sel_last;
  logic [DBIT-1:0] w_sel_data;
  logic            w_xfer;
  logic            w_found;
  logic [PW-1:0]   w_pick;
  logic [NREQ-1:0] w_pick_oh;
  logic [PW-1:0]   w_nxt_ptr;

  // Owner-side mux: the one-hot grant selects valid/last/data of the owner
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_grant[i]) begin
        w_sel_valid = i_req_valid[i];
        w_sel_last  = i_req_last[i];
        w_sel_data  = i_req_data[i*DBIT +: DBIT];
      end
    end
  end

  // Round-robin pick: first valid index scanning from r_ptr, wrapping at NREQ
  always_comb begin
    int j;
    j         = 0;
    w_found   = 1'b0;
    w_pick    = '0;
    w_pick_oh = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(r_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!w_found && i_req_valid[j]) begin
        w_found      = 1'b1;
        w_pick       = PW'(j);
        w_pick_oh[j] = 1'b1;
      end
    end
  end

  // Explicit wrap so non power-of-two NREQ never lands on an unused index
  assign w_nxt_ptr = (r_idx == PW'(NREQ-1)) ? '0 : r_idx + 1'b1;

  assign w_xfer        = (r_state == LOCK) && w_sel_valid && !i_tx_full;
  assign o_wr_uart     = w_xfer;
  assign o_req_ready   = (r_state == LOCK) ? (r_grant & {NREQ{~i_tx_full}}) : '0;
  assign o_w_data      = (r_state == LOCK) ? w_sel_data : '0;
  assign o_grant       = r_grant;
  assign o_busy        = (r_state == LOCK);
  assign o_timeout_err = r_tmo;

  // Arbitration FSM: grant on request, hold until last byte or watchdog expiry
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_idx   <= '0;
      r_ptr   <= '0;
      r_wd    <= '0;
      r_tmo   <= 1'b0;
    end else begin
      r_tmo <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state <= LOCK;
            r_grant <= w_pick_oh;
            r_idx   <= w_pick;
            r_wd    <= '0;
          end
        end
        LOCK: begin
          if (w_xfer) begin
            r_wd <= '0;
            if (w_sel_last) begin
              r_state <= IDLE;
              r_grant <= '0;
              r_ptr   <= w_nxt_ptr;
            end
          end else if (!w_sel_valid) begin
            // Silent cycle: release on the TIMEOUT-th consecutive one
            if (r_wd >= WW'(TIMEOUT-1)) begin
              r_state <= IDLE;
              r_grant <= '0;
              r_ptr   <= w_nxt_ptr;
              r_wd    <= '0;
              r_tmo   <= 1'b1;
            end else begin
              r_wd <= r_wd + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed, table-driven check of packet locking,
// round-robin order, back-pressure, watchdog release and mid-packet reset.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  vld;
  logic [31:0] dat;
  logic [3:0]  lst;
  logic        full;
  logic [3:0]  rdy;
  logic        wr;
  logic [7:0]  wd;
  logic [3:0]  gnt;
  logic        busy;
  logic        tmo;

  int n_cmp = 0;
  int n_err = 0;
  int step  = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NREQ(4), .DBIT(8), .TIMEOUT(4)) dut (
    .i_clk(clk), .i_reset(rst), .i_req_valid(vld), .i_req_data(dat),
    .i_req_last(lst), .o_req_ready(rdy), .i_tx_full(full), .o_wr_uart(wr),
    .o_w_data(wd), .o_grant(gnt), .o_busy(busy), .o_timeout_err(tmo)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  vld;
    logic [31:0] dat;
    logic [3:0]  lst;
    logic        full;
    logic        chk;
    logic [3:0]  e_gnt;
    logic        e_wr;
    logic [7:0]  e_wd;
    logic        e_busy;
    logic        e_tmo;
    logic [3:0]  e_rdy;
  } vec_t;

  function automatic vec_t V(logic r, logic [3:0] v, logic [31:0] d, logic [3:0] l,
                             logic f, logic c, logic [3:0] g, logic w, logic [7:0] x,
                             logic b, logic t, logic [3:0] y);
    vec_t o;
    o.rst = r; o.vld = v; o.dat = d; o.lst = l; o.full = f; o.chk = c;
    o.e_gnt = g; o.e_wr = w; o.e_wd = x; o.e_busy = b; o.e_tmo = t; o.e_rdy = y;
    return o;
  endfunction

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s step %0d: got %0h want %0h", nm, step, a, e);
    end
  endtask

  // Drive at negedge, compare 1 ns later, let the posedge commit
  task automatic apply(vec_t v);
    @(negedge clk);
    rst = v.rst; vld = v.vld; dat = v.dat; lst = v.lst; full = v.full;
    #1;
    if (v.chk) begin
      chk("grant", 32'(gnt), 32'(v.e_gnt));
      chk("busy", 32'(busy), 32'(v.e_busy));
      chk("wr_uart", 32'(wr), 32'(v.e_wr));
      chk("req_ready", 32'(rdy), 32'(v.e_rdy));
      chk("timeout_err", 32'(tmo), 32'(v.e_tmo));
      if (v.e_busy) chk("w_data", 32'(wd), 32'(v.e_wd));
    end
    step++;
  endtask

  vec_t tbl[$];

  initial begin
    rst = 1'b1; vld = '0; dat = '0; lst = '0; full = 1'b0;

    // Reset with all valid high, then req1 3-byte packet
    tbl.push_back(V(1, 4'hF, 0, 0, 0, 0, 4'h0, 0, 8'h00, 0, 0, 4'h0));
    tbl.push_back(V(1, 4'hF, 0, 0, 0, 1, 4'h0, 0, 8'h00, 0, 0, 4'h0));
    tbl.push_back(V(1, 4'hF, 0, 0, 0, 1, 4'h0, 0, 8'h00, 0, 0, 4'h0));
    tbl.push_back(V(0, 4'h0, 0, 0, 0, 1, 4'h0, 0, 8'h00, 0, 0, 4'h0));
    tbl.push_back(V(0, 4'h2, 32'h0000_A100, 4'h0, 0, 1, 4'h0, 0, 8'h00, 0, 0, 4'h0));
    tbl.push_back(V(0, 4'h2, 32'h0000_A100, 4'h0, 0, 1, 4'h2, 1, 8'hA1, 1, 0, 4'h2));
    tbl.push_back(V(0, 4'h2, 32'h0000_A200, 4'h0, 0, 1, 4'h2, 1, 8'hA2, 1, 0, 4'h2));
    tbl.push_back(V(0, 4'h2, 32'h0000_A300, 4'h2, 0, 1, 4'h2, 1, 8'hA3, 1, 0, 4'h2));
    tbl.push_back(V(0, 4'h0, 0, 0, 0, 1, 4'h0, 0, 8'h00, 0, 0, 4'h0));
    // Reset to ptr=0, then req0/req2 continuous 2-byte packets: 0,2,0,2
    tbl.push_back(V(1, 4'h0, 0, 0, 0, 0, 4'h0, 0, 8'h00, 0, 0, 4'h0));
    for (int p = 0; p < 4; p++) begin
      logic [3:0]  oh;
      logic [31:0] d0, d1;
      logic [7:0]  b0, b1;
      oh = (p % 2 == 0) ? 4'h1 : 4'h4;
      d0 = 32'h0020_000A;
      d1 = (p % 2 == 0) ? 32'h0020_000B : 32'h0021_000A;
      b0 = (p % 2 == 0) ? 8'h0A : 8'h20;
      b1 = (p % 2 == 0) ? 8'h0B : 8'h21;
      tbl.push_back(V(0, 4'h5, d0, 4'h0, 0, 1, 4'h0, 0, 8'h00, 0, 0, 4'h0));
      tbl.push_back(V(0, 4'h5, d0, 4'h0, 0, 1, oh, 1, b0, 1, 0, oh));
      tbl.push_back(V(0, 4'h5, d1, oh, 0, 1, oh, 1, b1, 1, 0, oh));
    end
    // ptr now 3: req3 gets grant, sends one byte
    tbl.push_back(V(0, 4'h8, 32'h3000_0000, 4'h0, 0, 1, 4'h0, 0, 8'h00, 0, 0, 4'h0));
    tbl.push_back(V(0, 4'h8, 32'h3000_0000, 4'h0, 0, 1, 4'h8, 1, 8'h30, 1, 0, 4'h8));

    foreach (tbl[i]) apply(tbl[i]);

    // Back-pressure: 10 full cycles, valid held, no watchdog count
    for (int c = 0; c < 10; c++)
      apply(V(0, 4'h8, 32'h3100_0000, 4'h8, 1, 1, 4'h8, 0, 8'h31, 1, 0, 4'h0));
    apply(V(0, 4'h8, 32'h3100_0000, 4'h8, 0, 1, 4'h8, 1, 8'h31, 1, 0, 4'h8));
    apply(V(0, 4'h0, 0, 0, 0, 1, 4'h0, 0, 8'h00, 0, 0, 4'h0));

    // Watchdog: ptr=0, only req3 asks, sends non-last byte then goes silent
    apply(V(0, 4'h8, 32'h3500_0000, 4'h0, 0, 1, 4'h0, 0, 8'h00, 0, 0, 4'h0));
    apply(V(0, 4'h9, 32'h3500_000C, 4'h0, 0, 1, 4'h8, 1, 8'h35, 1, 0, 4'h8));
    for (int s = 0; s < 4; s++)
      apply(V(0, 4'h1, 32'h3600_000C, 4'h1, 0, 1, 4'h8, 0, 8'h36, 1, 0, 4'h8));
    // Release cycle: req3 re-raises valid, ignored; ptr=0 so req0 picked
    apply(V(0, 4'h9, 32'h3600_000C, 4'h1, 0, 1, 4'h0, 0, 8'h00, 0, 1, 4'h0));
    apply(V(0, 4'h1, 32'h3600_000C, 4'h1, 0, 1, 4'h1, 1, 8'h0C, 1, 0, 4'h1));
    apply(V(0, 4'h0, 0, 0, 0, 1, 4'h0, 0, 8'h00, 0, 0, 4'h0));

    // Reset mid-packet of req2 (ptr=1)
    apply(V(0, 4'h4, 32'h0022_0000, 4'h0, 0, 1, 4'h0, 0, 8'h00, 0, 0, 4'h0));
    apply(V(0, 4'h4, 32'h0022_0000, 4'h0, 0, 1, 4'h4, 1, 8'h22, 1, 0, 4'h4));
    apply(V(1, 4'h4, 32'h0023_0000, 4'h0, 0, 0, 4'h0, 0, 8'h00, 0, 0, 4'h0));
    apply(V(0, 4'hF, 32'h4433_2211, 4'h0, 0, 1, 4'h0, 0, 8'h00, 0, 0, 4'h0));
    apply(V(0, 4'hF, 32'h4433_2211, 4'h0, 0, 1, 4'h1, 1, 8'h11, 1, 0, 4'h1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
